// File: rtl/dragon_body.sv
// Dragon game-logic stage: owns head/body segments, advances one tile per move,
// grows on request and runs a fixed six-cycle self-collision scan for the PPU.
module dragon_body #(
    parameter logic [3:0] HEAD_ID   = 4'h4,
    parameter logic [3:0] BODY_ID   = 4'h5,
    parameter logic [7:0] START_LOC = 8'h53
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move,
    input  logic [1:0]  dir,
    input  logic        grow,
    output logic [14:0] dragon_1,
    output logic [14:0] dragon_2,
    output logic [14:0] dragon_3,
    output logic [14:0] dragon_4,
    output logic [14:0] dragon_5,
    output logic [14:0] dragon_6,
    output logic [14:0] dragon_7,
    output logic [7:0]  head_loc,
    output logic [2:0]  length,
    output logic        busy,
    output logic        move_done,
    output logic        collision
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  seg [1:7];
    logic [2:0]  len_q;
    logic [2:0]  k;
    logic [1:0]  heading;
    logic        grow_pending;
    logic        coll_q;
    logic [3:0]  row_nxt, col_nxt;
    logic [7:0]  next_loc;

    // Rows run 0..11 only, so vertical moves wrap at 11 rather than 15.
    always_comb begin
        row_nxt = seg[1][7:4];
        col_nxt = seg[1][3:0];
        case (heading)
            2'b00:   row_nxt = (seg[1][7:4] == 4'd0)  ? 4'd11 : seg[1][7:4] - 4'd1;
            2'b01:   col_nxt = seg[1][3:0] + 4'd1;
            2'b10:   row_nxt = (seg[1][7:4] == 4'd11) ? 4'd0  : seg[1][7:4] + 4'd1;
            default: col_nxt = seg[1][3:0] - 4'd1;
        endcase
        next_loc = {row_nxt, col_nxt};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (move) state_nxt = SHIFT;
            SHIFT:   state_nxt = CHECK;
            CHECK:   if (k == 3'd7) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        move_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned n = 1; n <= 7; n++) seg[n] <= {2'b01, START_LOC};
            len_q        <= 3'd1;
            heading      <= 2'b01;
            grow_pending <= 1'b0;
            coll_q       <= 1'b0;
            k            <= 3'd2;
        end else begin
            if (grow) grow_pending <= 1'b1;
            case (state)
                IDLE: begin
                    // A reversal would fold the head into the neck, so it is ignored.
                    if (move && (dir != (heading ^ 2'b10))) heading <= dir;
                end
                SHIFT: begin
                    for (int unsigned n = 7; n >= 2; n--) seg[n] <= seg[n-1];
                    seg[1] <= {heading, next_loc};
                    if ((grow_pending || grow) && (len_q != 3'd7)) len_q <= len_q + 3'd1;
                    grow_pending <= 1'b0;
                    coll_q       <= 1'b0;
                    k            <= 3'd2;
                end
                CHECK: begin
                    if ((k <= len_q) && (seg[k][7:0] == seg[1][7:0])) coll_q <= 1'b1;
                    k <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign dragon_1  = {1'b0, HEAD_ID, seg[1]};
    assign dragon_2  = {(len_q < 3'd2), BODY_ID, seg[2]};
    assign dragon_3  = {(len_q < 3'd3), BODY_ID, seg[3]};
    assign dragon_4  = {(len_q < 3'd4), BODY_ID, seg[4]};
    assign dragon_5  = {(len_q < 3'd5), BODY_ID, seg[5]};
    assign dragon_6  = {(len_q < 3'd6), BODY_ID, seg[6]};
    assign dragon_7  = {(len_q < 3'd7), BODY_ID, seg[7]};
    assign head_loc  = seg[1][7:0];
    assign length    = len_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_dragon_body.sv
// Scoreboard bench for dragon_body: a behavioural model predicts each move's
// result when it is issued; predictions are popped and compared at move_done.
module tb_dragon_body;

    logic        clk = 1'b0;
    logic        reset, move, grow;
    logic [1:0]  dir;
    logic [14:0] dragon_1, dragon_2, dragon_3, dragon_4, dragon_5, dragon_6, dragon_7;
    logic [7:0]  head_loc;
    logic [2:0]  length;
    logic        busy, move_done, collision;

    dragon_body #(
        .HEAD_ID  (4'h4),
        .BODY_ID  (4'h5),
        .START_LOC(8'h53)
    ) dut (
        .clk(clk), .reset(reset), .move(move), .dir(dir), .grow(grow),
        .dragon_1(dragon_1), .dragon_2(dragon_2), .dragon_3(dragon_3), .dragon_4(dragon_4),
        .dragon_5(dragon_5), .dragon_6(dragon_6), .dragon_7(dragon_7),
        .head_loc(head_loc), .length(length), .busy(busy),
        .move_done(move_done), .collision(collision)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  head;
        logic [2:0]  len;
        logic        coll;
        logic [14:0] d1, d2, d7;
    } exp_t;

    exp_t sb[$];

    logic [9:0] m_seg [1:7];
    logic [2:0] m_len;
    logic [1:0] m_head;
    logic       m_pend;
    logic       m_coll;

    function automatic logic [7:0] step(input logic [7:0] loc, input logic [1:0] d);
        logic [3:0] r, c;
        r = loc[7:4];
        c = loc[3:0];
        case (d)
            2'd0: r = (r == 4'd0) ? 4'd11 : r - 4'd1;
            2'd1: c = c + 4'd1;
            2'd2: r = (r == 4'd11) ? 4'd0 : r + 4'd1;
            2'd3: c = c - 4'd1;
        endcase
        return {r, c};
    endfunction

    function automatic logic [14:0] m_word(input int n);
        if (n == 1) return {1'b0, 4'h4, m_seg[1]};
        return {(n > int'(m_len)), 4'h5, m_seg[n]};
    endfunction

    task automatic model_reset();
        for (int n = 1; n <= 7; n++) m_seg[n] = {2'b01, 8'h53};
        m_len  = 3'd1;
        m_head = 2'b01;
        m_pend = 1'b0;
        m_coll = 1'b0;
    endtask

    task automatic check_reset_state(input string p);
        check_eq({p, "_d1"}, dragon_1, {1'b0, 4'h4, 2'b01, 8'h53});
        check_eq({p, "_d2"}, dragon_2, {1'b1, 4'h5, 2'b01, 8'h53});
        check_eq({p, "_d7"}, dragon_7, {1'b1, 4'h5, 2'b01, 8'h53});
        check_eq({p, "_len"}, length, 3'd1);
        check_eq({p, "_busy"}, busy, 1'b0);
        check_eq({p, "_done"}, move_done, 1'b0);
        check_eq({p, "_coll"}, collision, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; move = 1'b0; grow = 1'b0; dir = 2'b00;
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_grow();
        @(negedge clk);
        grow = 1'b1;
        @(negedge clk);
        grow = 1'b0;
        m_pend = 1'b1;
    endtask

    // g_acc: grow with the move; g_shift: grow during SHIFT; dbl: extra move at T+4;
    // rst_mid: reset asserted during CHECK.
    task automatic run_move(input logic [1:0] d, input bit g_acc, input bit g_shift,
                            input bit dbl, input bit rst_mid);
        exp_t e, got;
        logic prev_coll;
        bit   done;
        prev_coll = m_coll;
        @(negedge clk);
        move = 1'b1; dir = d; grow = g_acc;
        if (g_acc) m_pend = 1'b1;
        if (d != (m_head ^ 2'b10)) m_head = d;
        for (int n = 7; n >= 2; n--) m_seg[n] = m_seg[n-1];
        m_seg[1] = {m_head, step(m_seg[2][7:0], m_head)};
        if ((m_pend || g_shift) && m_len != 3'd7) m_len = m_len + 3'd1;
        m_pend = 1'b0;
        m_coll = 1'b0;
        for (int n = 2; n <= 7; n++)
            if (n <= int'(m_len) && m_seg[n][7:0] == m_seg[1][7:0]) m_coll = 1'b1;
        e.head = m_seg[1][7:0]; e.len = m_len; e.coll = m_coll;
        e.d1 = m_word(1); e.d2 = m_word(2); e.d7 = m_word(7);
        sb.push_back(e);
        done = 1'b0;
        for (int i = 1; i <= 12 && !done; i++) begin
            @(negedge clk);
            move = 1'b0; grow = 1'b0;
            if (i == 1 && g_shift) grow = 1'b1;
            if (i == 4 && dbl) begin move = 1'b1; dir = d; end
            if (i == 1) check_eq("sticky_coll", collision, prev_coll);
            if (i == 2) begin
                check_eq("early_head", head_loc, e.head);
                check_eq("early_len", length, e.len);
                check_eq("coll_cleared", collision, 1'b0);
            end
            if (rst_mid) begin
                if (i == 4) reset = 1'b1;
                if (i == 5) begin
                    check_reset_state("midreset");
                    reset = 1'b0;
                    void'(sb.pop_front());
                    model_reset();
                    done = 1'b1;
                end
            end else if (move_done) begin
                check_eq("done_cycle", i, 8);
                got = sb.pop_front();
                check_eq("head", head_loc, got.head);
                check_eq("len", length, got.len);
                check_eq("coll", collision, got.coll);
                check_eq("d1", dragon_1, got.d1);
                check_eq("d2", dragon_2, got.d2);
                check_eq("d7", dragon_7, got.d7);
                done = 1'b1;
            end else begin
                check_eq("busy", busy, 1'b1);
            end
        end
        if (!done) check_eq("move_done_timeout", 1'b0, 1'b1);
        if (!rst_mid) begin
            @(negedge clk);
            check_eq("idle_busy", busy, 1'b0);
            check_eq("idle_done", move_done, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; move = 1'b0; grow = 1'b0; dir = 2'b00;
        model_reset();
        do_reset();

        run_move(2'd1, 0, 0, 0, 0);
        check_eq("first_move", head_loc, 8'h54);
        pulse_grow();
        run_move(2'd1, 0, 0, 0, 0);
        check_eq("grow_len", length, 3'd2);
        check_eq("grow_d2", dragon_2, {1'b0, 4'h5, 2'b01, 8'h54});
        check_eq("grow_head", head_loc, 8'h55);
        run_move(2'd3, 0, 0, 1, 0);
        check_eq("reverse_ignored", head_loc, 8'h56);
        repeat (9) run_move(2'd1, 0, 0, 0, 0);
        check_eq("col_edge", head_loc, 8'h5F);
        run_move(2'd1, 0, 0, 0, 0);
        check_eq("wrap_right", head_loc, 8'h50);
        repeat (3) run_move(2'd1, 1, 0, 0, 0);
        repeat (3) run_move(2'd1, 0, 1, 0, 0);
        check_eq("len_sat", length, 3'd7);
        run_move(2'd1, 1, 0, 0, 0);
        check_eq("len_sat2", length, 3'd7);

        do_reset();
        repeat (5) run_move(2'd0, 0, 0, 0, 0);
        check_eq("row0", head_loc, 8'h03);
        run_move(2'd0, 0, 0, 0, 0);
        check_eq("wrap_up", head_loc, 8'hB3);

        do_reset();
        repeat (6) run_move(2'd2, 0, 0, 0, 0);
        check_eq("row11", head_loc, 8'hB3);
        run_move(2'd2, 0, 0, 0, 0);
        check_eq("wrap_down", head_loc, 8'h03);

        do_reset();
        repeat (4) run_move(2'd1, 1, 0, 0, 0);
        check_eq("len5", length, 3'd5);
        run_move(2'd0, 0, 0, 0, 0);
        run_move(2'd3, 0, 0, 0, 0);
        check_eq("no_coll_yet", collision, 1'b0);
        run_move(2'd2, 0, 0, 0, 0);
        check_eq("self_hit", collision, 1'b1);
        run_move(2'd1, 0, 0, 0, 0);
        run_move(2'd0, 0, 0, 0, 0);
        run_move(2'd3, 0, 0, 0, 1);
        run_move(2'd1, 0, 0, 0, 0);
        check_eq("post_reset_move", head_loc, 8'h54);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dragon_body.md
# dragon_body

Game-logic stage directly upstream of the Picture Processing Unit. It owns the dragon's head position, heading and body segments, and advances them one tile per accepted move request. It grows the body on request and runs a multi-cycle self-collision check. It drives the seven 15-bit `dragon_1`…`dragon_7` slots the PPU reads, in the PPU's dragon format.

## Interface
Parameters:
- `HEAD_ID`, 4'h4: sprite ID for segment 1 (head).
- `BODY_ID`, 4'h5: sprite ID for segments 2–7.
- `START_LOC`, 8'h53: reset head tile, {row[7:4], col[3:0]}.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `move`, in, 1: one-cycle move request. Accepted only in IDLE.
- `dir`, in, 2: requested heading, sampled with `move`. 00 up, 01 right, 10 down, 11 left.
- `grow`, in, 1: one-cycle grow request. Latched in any state.
- `dragon_1`…`dragon_7`, out, 15 each: {hidden[14], ID[13:10], orient[9:8], loc[7:0]}. hidden=1 blanks the slot.
- `head_loc`, out, 8: equals `dragon_1[7:0]`.
- `length`, out, 3: visible segments, 1–7.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `move_done`, out, 1: one-cycle pulse when a move completes. `collision` is valid in the same cycle.
- `collision`, out, 1: head overlaps a visible body segment.

## Operation
- Storage: seg[1..7], each holding {orient, loc}, plus `length`, `heading`, `grow_pending`, and a 3-bit check index `k`.
- Output mapping:
  - `dragon_1` = {1'b0, HEAD_ID, seg1}.
  - `dragon_n` (n≥2) = {(n > length), BODY_ID, seg_n}.
- FSM states: IDLE → SHIFT → CHECK → DONE → IDLE.
- IDLE:
  - On `move`=1, latch `dir`.
  - If `dir` is the exact opposite of `heading` (00↔10, 01↔11), keep `heading`. Otherwise `heading` ← `dir`.
  - Go to SHIFT.
- SHIFT (one cycle):
  - seg[n] ← seg[n-1] for n=7..2.
  - seg1 ← {heading, next_loc}.
  - If `grow_pending` and `length` < 7: `length`++.
  - Clear `grow_pending`. A grow request arriving at `length` = 7 is discarded.
  - Clear `collision`, set k ← 2, go to CHECK.
- next_loc arithmetic (4-bit fields):
  - Right: col+1 mod 16. Left: col−1 mod 16.
  - Down: row+1, with 11 wrapping to 0. Up: row−1, with 0 wrapping to 11.
  - Rows 12–15 never occur.
- CHECK (six cycles, k = 2..7, fixed regardless of `length`):
  - If k ≤ `length` and seg[k].loc == seg1.loc, set `collision`.
  - After k = 7, go to DONE.
- DONE (one cycle): `move_done` = 1, then go to IDLE.
- `grow`:
  - Sets `grow_pending` in any state.
  - If `grow` coincides with the SHIFT cycle, it is applied in that SHIFT.
  - If `grow` coincides with an accepted `move` in IDLE, it is applied in the following SHIFT.
- `move` while `busy` is dropped. There is no queue.
- `collision` is sticky: it holds from DONE until the next SHIFT.
- Reset values, applied from any state including mid-check:
  - FSM = IDLE, `length` = 1, `heading` = 01, `grow_pending` = 0.
  - All seg = {01, START_LOC}.
  - `busy`, `move_done`, `collision` = 0.
  - Resulting outputs: `dragon_1` = {0, HEAD_ID, 01, START_LOC}. `dragon_2`–`dragon_7` = {1, BODY_ID, 01, START_LOC}.

## Timing
- `move` sampled at cycle T. SHIFT runs in T+1.
- New segment outputs and `length` are visible from T+2.
- CHECK occupies T+2…T+7.
- DONE is T+8: `move_done` = 1 and `collision` is valid.
- `busy` = 1 for T+1…T+8. The next `move` can be accepted at T+9.
- Maximum move rate is 1 per 9 cycles. A frame-rate `move` therefore never collides with `busy`.
- All outputs are registered. There are no combinational paths from any input to any output.
- Segment outputs change only on the SHIFT clock edge. The PPU therefore never sees a partially shifted body within a cycle.

## Test plan
- Reset with `START_LOC` = 8'h53 → `dragon_1` = {0, HEAD_ID, 01, 8'h53}; `dragon_2`…`dragon_7` have hidden = 1; `length` = 1; `busy` = 0.
- `move`, `dir` = 01 from 0x53 → at T+2 `head_loc` = 0x54; `busy` high T+1…T+8; `move_done` at T+8 with `collision` = 0.
- Wrap checks:
  - Head 0x5F, move right → 0x50.
  - Head 0x03, move up → 0xB3.
  - Head 0xB3, move down → 0x03.
- `grow` pulse, then move right from 0x54 → `length` = 2; `dragon_2` = {0, BODY_ID, 01, 0x54}; `dragon_1` loc = 0x55. At `length` = 7, a further grow plus move leaves `length` = 7.
- Heading right, `dir` = 11 → heading stays 01 and head moves right. A second `move` issued at T+4 is ignored: exactly one shift occurs.
- Grow to `length` = 5, then move up, left, down, right in a loop → the move that lands the head on a body tile gives `collision` = 1 at DONE. `collision` clears at the next SHIFT. Asserting `reset` during CHECK restores all reset values on the next cycle.
